button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 10 +
 rtl/button_channel.sv | 116 +++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the button conditioner: per-channel gesture state encoding.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce, press/hold/repeat FSM.
// release/repeat are SystemVerilog keywords, hence the _pulse port names.
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_WIDTH  = 19,
  parameter int LONG_WIDTH = 25,
  parameter int REP_WIDTH  = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  logic                  sync_meta, sync_q;
  logic [DEB_WIDTH-1:0]  deb_cnt, deb_cnt_d;
  logic [LONG_WIDTH-1:0] hold_cnt, hold_cnt_d;
  logic [REP_WIDTH-1:0]  rep_cnt, rep_cnt_d;
  btn_state_e            state, state_d;
  logic                  level_d, press_d, release_d, long_d, repeat_d;
  logic                  deb_fire, rise, fall;

  // A level change needs 2^DEB_WIDTH consecutive mismatching cycles.
  assign deb_fire = (sync_q != level) && (&deb_cnt);
  assign rise     = deb_fire && sync_q;
  assign fall     = deb_fire && !sync_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    level_d    = level;
    deb_cnt_d  = deb_cnt + 1'b1;
    state_d    = state;
    hold_cnt_d = hold_cnt;
    rep_cnt_d  = rep_cnt;
    press_d    = rise;
    release_d  = fall;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    if (sync_q == level) begin
      deb_cnt_d = '0;
    end else if (deb_fire) begin
      level_d   = sync_q;
      deb_cnt_d = '0;
    end

    // A falling level wins over any hold or repeat event on the same edge.
    if (fall) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          hold_cnt_d = hold_cnt + 1'b1;
          if (&hold_cnt) begin
            state_d   = HELD;
            rep_cnt_d = '0;
            long_d    = 1'b1;
          end
        end
        HELD: begin
          if (repeat_en) begin
            rep_cnt_d = rep_cnt + 1'b1;
            repeat_d  = &rep_cnt;
          end else begin
            rep_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      sync_meta     <= 1'b0;
      sync_q        <= 1'b0;
      deb_cnt       <= '0;
      level         <= 1'b0;
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync_meta     <= din;
      sync_q        <= sync_meta;
      deb_cnt       <= deb_cnt_d;
      level         <= level_d;
      state         <= state_d;
      hold_cnt      <= hold_cnt_d;
      rep_cnt       <= rep_cnt_d;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced buttons with press/release/long-press/repeat pulses.
module button_conditioner #(
  parameter int N_BTN      = 4,
  parameter int DEB_WIDTH  = 19,
  parameter int LONG_WIDTH = 25,
  parameter int REP_WIDTH  = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] din,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEB_WIDTH (DEB_WIDTH),
      .LONG_WIDTH(LONG_WIDTH),
      .REP_WIDTH (REP_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .din          (din[i]),
      .repeat_en    (repeat_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a timing-rule reference model.
module tb_button_conditioner;

  localparam int N = 2;
  localparam int DEB_CYC  = 8;   // 2^3
  localparam int LONG_CYC = 32;  // 2^5
  localparam int REP_CYC  = 8;   // 2^3

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din, repeat_en;
  logic [N-1:0] level, press, release_pulse, long_press, repeat_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model: level flips when the 2-cycle-delayed input has differed
  // from it on each of the last DEB_CYC edges; gestures are timed by age.
  bit       dh [N][DEB_CYC+1];
  bit [N-1:0] m_level;
  int       phase   [N];
  int       age     [N];
  int       rep_run [N];
  logic [N-1:0] exp_level, exp_press, exp_release, exp_long, exp_rep;

  button_conditioner #(
    .N_BTN(2), .DEB_WIDTH(3), .LONG_WIDTH(5), .REP_WIDTH(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .repeat_en    (repeat_en),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_press = '0; exp_release = '0; exp_long = '0; exp_rep = '0;
    if (reset) begin
      m_level = '0;
      for (int ch = 0; ch < N; ch++) begin
        phase[ch] = 0; age[ch] = 0; rep_run[ch] = 0;
        for (int k = 0; k <= DEB_CYC; k++) dh[ch][k] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        bit flip, rise, fall;
        flip = 1'b1;
        for (int k = 1; k <= DEB_CYC; k++) if (dh[ch][k] == m_level[ch]) flip = 1'b0;
        rise = flip && !m_level[ch];
        fall = flip && m_level[ch];
        if (flip) m_level[ch] = ~m_level[ch];
        exp_press[ch]   = rise;
        exp_release[ch] = fall;
        if (fall) begin
          phase[ch] = 0; rep_run[ch] = 0;
        end else if (phase[ch] == 0) begin
          if (rise) begin phase[ch] = 1; age[ch] = 0; end
        end else if (phase[ch] == 1) begin
          age[ch]++;
          if (age[ch] == LONG_CYC) begin
            phase[ch] = 2; exp_long[ch] = 1'b1; rep_run[ch] = 0;
          end
        end else if (repeat_en[ch]) begin
          rep_run[ch]++;
          if (rep_run[ch] % REP_CYC == 0) exp_rep[ch] = 1'b1;
        end else begin
          rep_run[ch] = 0;
        end
        for (int k = DEB_CYC; k > 0; k--) dh[ch][k] = dh[ch][k-1];
        dh[ch][0] = din[ch];
      end
    end
    exp_level = m_level;
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("level",      level,         exp_level);
    check("press",      press,         exp_press);
    check("release",    release_pulse, exp_release);
    check("long_press", long_press,    exp_long);
    check("repeat",     repeat_pulse,  exp_rep);
  endtask

  function automatic logic [N-1:0] sig(input int kind);
    case (kind)
      0:       return press;
      1:       return long_press;
      2:       return repeat_pulse;
      default: return release_pulse;
    endcase
  endfunction

  // Ticks until the chosen pulse appears on channel ch; n = -1 if the bound expires.
  task automatic wait_pulse(input int kind, input int ch, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (sig(kind)[ch]) begin n = k; break; end
    end
  endtask

  initial begin
    int n, cnt_long, cnt_rep, act;
    int rem [N];

    reset = 1'b1; din = '0; repeat_en = '0;
    tick(); tick();
    check("rst_outputs", {level, press, release_pulse, long_press, repeat_pulse}, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Clean press, long press and repeats on channel 0.
    repeat_en = 2'b01;
    din = 2'b01;
    wait_pulse(0, 0, 20, n);
    check("clean_press_lat", n, 10);
    check("ch1_quiet", {level[1], press[1]}, 0);
    tick();
    check("press_width", press[0], 0);
    wait_pulse(1, 0, 60, n);
    check("long_lat", n + 1, LONG_CYC);
    wait_pulse(2, 0, 20, n);
    check("rep1_lat", n, REP_CYC);
    wait_pulse(2, 0, 20, n);
    check("rep2_lat", n, REP_CYC);
    din = 2'b00;
    wait_pulse(3, 0, 20, n);
    check("release_lat", n, 10);
    repeat (5) tick();

    // Long hold with repeat disabled.
    repeat_en = 2'b00;
    din = 2'b01;
    wait_pulse(0, 0, 20, n);
    check("press_lat_noen", n, 10);
    cnt_long = 0; cnt_rep = 0;
    repeat (80) begin
      tick();
      cnt_long += long_press[0];
      cnt_rep  += repeat_pulse[0];
    end
    check("long_count_noen", cnt_long, 1);
    check("rep_count_noen", cnt_rep, 0);
    din = 2'b00;
    wait_pulse(3, 0, 20, n);
    check("release_lat_noen", n, 10);
    repeat (5) tick();

    // Bounce: every pulse shorter than the debounce window.
    act = 0;
    din = 2'b01; repeat (5) begin tick(); act |= level[0] | press[0] | release_pulse[0]; end
    din = 2'b00; repeat (3) begin tick(); act |= level[0] | press[0] | release_pulse[0]; end
    din = 2'b01; repeat (7) begin tick(); act |= level[0] | press[0] | release_pulse[0]; end
    din = 2'b00; repeat (20) begin tick(); act |= level[0] | press[0] | release_pulse[0]; end
    check("bounce_quiet", act, 0);

    // Simultaneous press, then reset while HELD.
    repeat_en = 2'b11;
    din = 2'b11;
    wait_pulse(0, 0, 20, n);
    check("simul_press_lat", n, 10);
    check("simul_press", press, 2'b11);
    wait_pulse(1, 0, 60, n);
    check("simul_long", long_press, 2'b11);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_held_outputs", {level, press, release_pulse, long_press, repeat_pulse}, 0);
    reset = 1'b0;
    wait_pulse(0, 0, 20, n);
    check("press_after_rst_lat", n, 10);
    check("press_after_rst", press, 2'b11);
    din = 2'b00;
    repeat (15) tick();

    // Randomized segments of random length per channel, occasional reset.
    rem[0] = 0; rem[1] = 0;
    repeat (3000) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          din[ch]       = ~din[ch];
          repeat_en[ch] = 1'($urandom_range(0, 1));
          rem[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7)
                                                : $urandom_range(8, 70);
        end
        rem[ch]--;
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
